// File: rtl/conv_window_gen_module.sv
// conv_window_gen_module
// Purpose : keeps a 3-column sliding window over padded image columns and emits one 3x3
//           pixel window per cycle, tagged with its top row / left column index.
// Ports   : clk, rst         - clock, synchronous active-high reset
//           col_data/col_sof/col_vld/col_ready - column input handshake (1-deep pending reg)
//           win_data/win_vld/win_ready         - window output handshake
//           win_row/win_col/win_last           - window tags
// Config  : define WINGEN_STRIDE2_EN to emit only even rows and even columns (stride 2).
module conv_window_gen_module #(
   parameter int unsigned ROWS = 26,
   parameter int unsigned COLS = 34,
   parameter int unsigned DW   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ROWS*DW-1:0]   col_data,
   input  logic                 col_sof,
   input  logic                 col_vld,
   output logic                 col_ready,
   output logic [9*DW-1:0]      win_data,
   output logic                 win_vld,
   input  logic                 win_ready,
   output logic [4:0]           win_row,
   output logic [5:0]           win_col,
   output logic                 win_last
);

`ifdef WINGEN_STRIDE2_EN
   localparam int unsigned STEP = 2;
`else
   localparam int unsigned STEP = 1;
`endif
   // Largest emitted row/column index: highest multiple of STEP not exceeding the limit.
   localparam int unsigned LAST_ROW = ((ROWS - 3) / STEP) * STEP;
   localparam int unsigned LAST_COL = ((COLS - 3) / STEP) * STEP;

   localparam logic [4:0] STEP_W     = 5'(STEP);
   localparam logic [4:0] LAST_ROW_W = 5'(LAST_ROW);
   localparam logic [5:0] LAST_COL_W = 6'(LAST_COL);
   localparam logic [5:0] COLS_W     = 6'(COLS);

   typedef enum logic [1:0] {StFill, StEmit, StWait} state_e;

   state_e              state_q, state_d;
   logic                pend_full_q, pend_full_d;
   logic                pend_sof_q, pend_sof_d;
   logic [ROWS*DW-1:0]  pend_data_q, pend_data_d;
   logic [ROWS*DW-1:0]  c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
   logic [5:0]          col_cnt_q, col_cnt_d;
   logic [4:0]          row_q, row_d;
   logic [5:0]          win_col_q, win_col_d;
   logic                win_vld_q, win_vld_d;
   logic [15:0]         err_cnt_q, err_cnt_d;

   logic       accept, win_hs, last_hs, xfer, emit_ok;
   logic [5:0] cnt_next, col_next;

   always_comb begin
      accept  = col_vld && !pend_full_q;
      win_hs  = win_vld_q && win_ready;
      last_hs = win_hs && (row_q == LAST_ROW_W);
      // In EMIT the next column may only enter once the current column's last row is taken.
      xfer    = pend_full_q &&
                ((state_q != StEmit) || (last_hs && (col_cnt_q != COLS_W)));
      cnt_next = col_cnt_q + 6'd1;
      col_next = cnt_next - 6'd3;
`ifdef WINGEN_STRIDE2_EN
      emit_ok = !col_next[0];
`else
      emit_ok = 1'b1;
`endif

      state_d     = state_q;
      pend_full_d = pend_full_q;
      pend_sof_d  = pend_sof_q;
      pend_data_d = pend_data_q;
      c0_d        = c0_q;
      c1_d        = c1_q;
      c2_d        = c2_q;
      col_cnt_d   = col_cnt_q;
      row_d       = row_q;
      win_col_d   = win_col_q;
      err_cnt_d   = err_cnt_q;

      if (accept) begin
         pend_data_d = col_data;
         pend_sof_d  = col_sof;
         pend_full_d = 1'b1;
      end

      if (win_hs && !last_hs) begin
         row_d = row_q + STEP_W;
      end

      if (last_hs) begin
         row_d = '0;
         if (col_cnt_q == COLS_W) begin
            state_d   = StFill;
            col_cnt_d = '0;
         end else if (!pend_full_q) begin
            state_d = StWait;
         end
      end

      if (xfer) begin
         pend_full_d = 1'b0;
         row_d       = '0;
         if (pend_sof_q) begin
            // New frame: older columns are stale, restart the fill.
            c0_d      = '0;
            c1_d      = '0;
            c2_d      = pend_data_q;
            col_cnt_d = 6'd1;
            state_d   = StFill;
         end else if (col_cnt_q == '0) begin
            // Column outside any frame: consume it but keep it out of the window.
            if (err_cnt_q != '1) begin
               err_cnt_d = err_cnt_q + 16'd1;
            end
            state_d = StFill;
         end else begin
            c0_d      = c1_q;
            c1_d      = c2_q;
            c2_d      = pend_data_q;
            col_cnt_d = cnt_next;
            if (cnt_next < 6'd3) begin
               state_d = StFill;
            end else if (emit_ok) begin
               state_d   = StEmit;
               win_col_d = col_next;
            end else if (cnt_next == COLS_W) begin
               // Trailing column that produces no window closes the frame.
               state_d   = StFill;
               col_cnt_d = '0;
            end else begin
               state_d = StWait;
            end
         end
      end

      win_vld_d = (state_d == StEmit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StFill;
         pend_full_q <= 1'b0;
         pend_sof_q  <= 1'b0;
         pend_data_q <= '0;
         c0_q        <= '0;
         c1_q        <= '0;
         c2_q        <= '0;
         col_cnt_q   <= '0;
         row_q       <= '0;
         win_col_q   <= '0;
         win_vld_q   <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         pend_full_q <= pend_full_d;
         pend_sof_q  <= pend_sof_d;
         pend_data_q <= pend_data_d;
         c0_q        <= c0_d;
         c1_q        <= c1_d;
         c2_q        <= c2_d;
         col_cnt_q   <= col_cnt_d;
         row_q       <= row_d;
         win_col_q   <= win_col_d;
         win_vld_q   <= win_vld_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   // Window mux: rows row_q..row_q+2 of c0 (oldest) .. c2 (newest).
   always_comb begin
      win_data = '0;
      for (int dr = 0; dr < 3; dr++) begin
         win_data[9*DW-1-(dr*3+0)*DW -: DW] = c0_q[ROWS*DW-1-(int'(row_q)+dr)*DW -: DW];
         win_data[9*DW-1-(dr*3+1)*DW -: DW] = c1_q[ROWS*DW-1-(int'(row_q)+dr)*DW -: DW];
         win_data[9*DW-1-(dr*3+2)*DW -: DW] = c2_q[ROWS*DW-1-(int'(row_q)+dr)*DW -: DW];
      end
   end

   assign col_ready = !pend_full_q;
   assign win_vld   = win_vld_q;
   assign win_row   = row_q;
   assign win_col   = win_col_q;
   assign win_last  = (row_q == LAST_ROW_W) && (win_col_q == LAST_COL_W);

endmodule
